fork_nway_fflop: RTL and testbench

FORK_NWAY_FFLOP -- requirements
Module: fork_nway_fflop

---
 rtl/fork_nway_fflop_pkg.sv | 11 +
 rtl/fork_nway_fflop_fflop.sv | 87 ++++++++
 rtl/fork_nway_fflop.sv | 61 ++++++
 tb/tb_fork_nway_fflop.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fork_nway_fflop_pkg.sv
// Shared constants for the eager N-way fork with per-branch 2-entry buffers.
package fork_nway_fflop_pkg;

    localparam int unsigned DEFAULT_SIZE = 8;
    localparam int unsigned DEFAULT_NOUT = 2;
    localparam int unsigned MIN_SIZE     = 1;
    localparam int unsigned MAX_SIZE     = 64;
    localparam int unsigned MIN_NOUT     = 2;
    localparam int unsigned MAX_NOUT     = 8;

endpackage : fork_nway_fflop_pkg

// File: rtl/fork_nway_fflop_fflop.sv
// Two-entry buffer with one-cycle latency; input retry is registered and
// asserted exactly when both entries are occupied.
module fork_nway_fflop_fflop
    import fork_nway_fflop_pkg::*;
#(
    parameter int unsigned Size = DEFAULT_SIZE
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [Size-1:0] din_i,
    input  logic            din_valid_i,
    output logic            din_retry_o,
    output logic [Size-1:0] dout_o,
    output logic            dout_valid_o,
    input  logic            dout_retry_i
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    occ_e            state_q, state_d;
    logic [Size-1:0] head_q, head_d;
    logic [Size-1:0] tail_q, tail_d;
    logic            valid_q, full_q;
    logic            push, pop;

    // Occupancy register; valid and full are registered copies of the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= OCC_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= (state_d != OCC_EMPTY);
            full_q  <= (state_d == OCC_TWO);
        end
    end

    // Head entry always drives the output; a push into a full buffer cannot
    // happen because retry already blocks it.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        push    = din_valid_i & ~full_q;
        pop     = valid_q & ~dout_retry_i;
        case (state_q)
            OCC_EMPTY: begin
                if (push) begin
                    head_d  = din_i;
                    state_d = OCC_ONE;
                end
            end
            OCC_ONE: begin
                case ({push, pop})
                    2'b10: begin
                        tail_d  = din_i;
                        state_d = OCC_TWO;
                    end
                    2'b01: state_d = OCC_EMPTY;
                    2'b11: head_d  = din_i;
                    default: state_d = OCC_ONE;
                endcase
            end
            OCC_TWO: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = OCC_ONE;
                end
            end
            default: state_d = OCC_EMPTY;
        endcase
    end

    assign din_retry_o  = full_q;
    assign dout_o       = head_q;
    assign dout_valid_o = valid_q;

endmodule : fork_nway_fflop_fflop

// File: rtl/fork_nway_fflop.sv
// Eager N-way fork: each masked branch takes the payload independently, and
// a done vector remembers which branches already have it until all do.
module fork_nway_fflop
    import fork_nway_fflop_pkg::*;
#(
    parameter int unsigned Size = DEFAULT_SIZE,
    parameter int unsigned Nout = DEFAULT_NOUT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [Size-1:0]      inp,
    input  logic [Nout-1:0]      inp_Mask,
    input  logic                 inp_Valid,
    output logic                 inp_Retry,
    output logic [Nout*Size-1:0] out,
    output logic [Nout-1:0]      outValid,
    input  logic [Nout-1:0]      outRetry
);

    logic [Nout-1:0] done_q, done_d;
    logic [Nout-1:0] br_retry;
    logic [Nout-1:0] offer;
    logic [Nout-1:0] accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= '0;
        end else begin
            done_q <= done_d;
        end
    end

    // Offers are suppressed during reset so nothing is taken and no retry is seen.
    always_comb begin
        offer     = {Nout{inp_Valid & ~reset}} & inp_Mask & ~done_q;
        accept    = offer & ~br_retry;
        inp_Retry = |(offer & br_retry);
        done_d    = done_q;
        if (inp_Valid && !inp_Retry) begin
            done_d = '0;
        end else if (inp_Valid) begin
            done_d = done_q | accept;
        end
    end

    for (genvar g = 0; g < int'(Nout); g++) begin : g_branch
        fork_nway_fflop_fflop #(
            .Size(Size)
        ) u_fflop (
            .clk          (clk),
            .reset        (reset),
            .din_i        (inp),
            .din_valid_i  (accept[g]),
            .din_retry_o  (br_retry[g]),
            .dout_o       (out[g*Size +: Size]),
            .dout_valid_o (outValid[g]),
            .dout_retry_i (outRetry[g])
        );
    end

endmodule : fork_nway_fflop

// File: tb/tb_fork_nway_fflop.sv
// Directed vector table, a streaming run and a random scoreboard for the fork.
module tb_fork_nway_fflop;

    localparam int unsigned NOUT  = 3;
    localparam int unsigned SIZE  = 8;
    localparam int unsigned NRAND = 3000;

    logic                 clk;
    logic                 reset;
    logic [SIZE-1:0]      inp;
    logic [NOUT-1:0]      inp_mask;
    logic                 inp_valid;
    logic                 inp_retry;
    logic [NOUT*SIZE-1:0] out_w;
    logic [NOUT-1:0]      out_valid;
    logic [NOUT-1:0]      out_retry;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] data;
        logic [2:0] mask;
        logic [2:0] oretry;
        logic       exp_ir;
        logic [2:0] exp_ov;
        logic [7:0] e0;
        logic [7:0] e1;
        logic [7:0] e2;
    } vec_t;

    vec_t vecs [19];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];

    fork_nway_fflop #(
        .Size(SIZE),
        .Nout(NOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .inp       (inp),
        .inp_Mask  (inp_mask),
        .inp_Valid (inp_valid),
        .inp_Retry (inp_retry),
        .out       (out_w),
        .outValid  (out_valid),
        .outRetry  (out_retry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] lane(input int b);
        return out_w[b*SIZE +: SIZE];
    endfunction

    function automatic int qsz(input int b);
        case (b)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic qpush(input int b, input logic [7:0] d);
        case (b)
            0: q0.push_back(d);
            1: q1.push_back(d);
            default: q2.push_back(d);
        endcase
    endtask

    task automatic qpop_chk(input int b, input logic [7:0] act);
        logic [7:0] e;
        if (qsz(b) == 0) begin
            checks++;
            failures++;
            $display("FAIL rand_unexpected_b%0d: got %0h expected no delivery", b, act);
        end else begin
            case (b)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            chk($sformatf("rand_data_b%0d", b), 64'(act), 64'(e));
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [7:0] d,
                         input logic [2:0] m, input logic [2:0] orr);
        reset     = r;
        inp_valid = v;
        inp       = d;
        inp_mask  = m;
        out_retry = orr;
    endtask

    initial begin
        int  cyc;
        int  sent;
        bit  need_new;

        // rst, vld, data, mask, oretry, exp_ir, exp_ov, e0, e1, e2
        vecs[0]  = '{1'b1, 1'b1, 8'h11, 3'b111, 3'b000, 1'b0, 3'b000, 8'h00, 8'h00, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 8'h3C, 3'b010, 3'b000, 1'b0, 3'b000, 8'h00, 8'h00, 8'h00};
        vecs[2]  = '{1'b0, 1'b1, 8'h77, 3'b000, 3'b000, 1'b0, 3'b010, 8'h00, 8'h3C, 8'h00};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 3'b000, 3'b000, 1'b0, 3'b000, 8'h00, 8'h00, 8'h00};
        vecs[4]  = '{1'b0, 1'b1, 8'hA5, 3'b111, 3'b010, 1'b0, 3'b000, 8'h00, 8'h00, 8'h00};
        vecs[5]  = '{1'b0, 1'b1, 8'hA6, 3'b111, 3'b010, 1'b0, 3'b111, 8'hA5, 8'hA5, 8'hA5};
        vecs[6]  = '{1'b0, 1'b1, 8'hA7, 3'b111, 3'b010, 1'b1, 3'b111, 8'hA6, 8'hA5, 8'hA6};
        vecs[7]  = '{1'b0, 1'b1, 8'hA7, 3'b111, 3'b010, 1'b1, 3'b111, 8'hA7, 8'hA5, 8'hA7};
        vecs[8]  = '{1'b0, 1'b1, 8'hA7, 3'b111, 3'b000, 1'b1, 3'b010, 8'h00, 8'hA5, 8'h00};
        vecs[9]  = '{1'b0, 1'b1, 8'hA7, 3'b111, 3'b000, 1'b0, 3'b010, 8'h00, 8'hA6, 8'h00};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 3'b000, 3'b000, 1'b0, 3'b010, 8'h00, 8'hA7, 8'h00};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 3'b000, 3'b000, 1'b0, 3'b000, 8'h00, 8'h00, 8'h00};
        vecs[12] = '{1'b0, 1'b1, 8'hB1, 3'b011, 3'b110, 1'b0, 3'b000, 8'h00, 8'h00, 8'h00};
        vecs[13] = '{1'b0, 1'b1, 8'hB2, 3'b111, 3'b110, 1'b0, 3'b011, 8'hB1, 8'hB1, 8'h00};
        vecs[14] = '{1'b0, 1'b1, 8'hB3, 3'b111, 3'b110, 1'b1, 3'b111, 8'hB2, 8'hB1, 8'hB2};
        vecs[15] = '{1'b1, 1'b1, 8'hB3, 3'b111, 3'b110, 1'b0, 3'b111, 8'hB3, 8'hB1, 8'hB2};
        vecs[16] = '{1'b0, 1'b1, 8'h55, 3'b111, 3'b000, 1'b0, 3'b000, 8'h00, 8'h00, 8'h00};
        vecs[17] = '{1'b0, 1'b0, 8'h00, 3'b000, 3'b000, 1'b0, 3'b111, 8'h55, 8'h55, 8'h55};
        vecs[18] = '{1'b0, 1'b0, 8'h00, 3'b000, 3'b000, 1'b0, 3'b000, 8'h00, 8'h00, 8'h00};

        drive(1'b1, 1'b0, 8'h00, 3'b000, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outvalid", 64'(out_valid), 64'(3'b000));
        chk("reset_inp_retry", 64'(inp_retry), 64'(1'b0));

        // Directed table: outputs reflect earlier rows, inp_Retry the current row.
        for (int i = 0; i < 19; i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].rst, vecs[i].vld, vecs[i].data, vecs[i].mask, vecs[i].oretry);
            #1;
            chk($sformatf("vec%0d_inp_retry", i), 64'(inp_retry), 64'(vecs[i].exp_ir));
            chk($sformatf("vec%0d_outvalid", i), 64'(out_valid), 64'(vecs[i].exp_ov));
            if (vecs[i].exp_ov[0]) chk($sformatf("vec%0d_out0", i), 64'(lane(0)), 64'(vecs[i].e0));
            if (vecs[i].exp_ov[1]) chk($sformatf("vec%0d_out1", i), 64'(lane(1)), 64'(vecs[i].e1));
            if (vecs[i].exp_ov[2]) chk($sformatf("vec%0d_out2", i), 64'(lane(2)), 64'(vecs[i].e2));
        end

        // Back-to-back stream with no back-pressure.
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            #1;
            if (k <= 16) drive(1'b0, 1'b1, 8'(k), 3'b111, 3'b000);
            else         drive(1'b0, 1'b0, 8'h00, 3'b000, 3'b000);
            #1;
            chk($sformatf("stream%0d_inp_retry", k), 64'(inp_retry), 64'(1'b0));
            if (k > 1) begin
                chk($sformatf("stream%0d_outvalid", k), 64'(out_valid), 64'(3'b111));
                for (int b = 0; b < 3; b++)
                    chk($sformatf("stream%0d_out%0d", k, b), 64'(lane(b)), 64'(8'(k - 1)));
            end
        end
        @(posedge clk);
        #1;
        chk("stream_idle_outvalid", 64'(out_valid), 64'(3'b000));

        // Random scoreboard with random masks and 30% consumer back-pressure.
        sent     = 0;
        cyc      = 0;
        need_new = 1'b1;
        while ((sent < int'(NRAND) || qsz(0) != 0 || qsz(1) != 0 || qsz(2) != 0) && cyc < 40000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (need_new) begin
                if (sent < int'(NRAND) && $urandom_range(0, 9) < 8) begin
                    inp_valid = 1'b1;
                    inp       = 8'($urandom);
                    inp_mask  = 3'($urandom_range(0, 7));
                    for (int b = 0; b < 3; b++)
                        if (inp_mask[b]) qpush(b, inp);
                    sent++;
                end else begin
                    inp_valid = 1'b0;
                end
            end
            for (int b = 0; b < 3; b++)
                out_retry[b] = ($urandom_range(0, 9) < 3);
            #3;
            for (int b = 0; b < 3; b++)
                if (out_valid[b] && !out_retry[b]) qpop_chk(b, lane(b));
            need_new = !inp_valid || !inp_retry;
        end
        if (cyc >= 40000) begin
            checks++;
            failures++;
            $display("FAIL rand_timeout: got %0d cycles expected under 40000", cyc);
        end
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 8'h00, 3'b000, 3'b000);
        for (int b = 0; b < 3; b++)
            chk($sformatf("rand_leftover_b%0d", b), 64'(qsz(b)), 64'(0));
        repeat (2) begin
            #1;
            chk("rand_no_extra_outvalid", 64'(out_valid), 64'(3'b000));
            @(posedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fork_nway_fflop
